// File: rtl/cram_unload_streamer.sv
// Purpose: on start, read N words from one CRAM port and stream them out as valid/last beats.
// Latency: start edge to first beat is 3 cycles; one beat per cycle when not stalled.
// Backpressure: stall holds the output; reads pause once FIFO occupancy plus in-flight reaches FIFO_DEPTH.
//
// Ports:
//   clk, reset                       rising-edge clock, asynchronous active-high reset
//   start, cram_addr_start, num_words  transfer request (address and length sampled with start)
//   cram_addr, cram_re, cram_data_in   CRAM read port (data arrives one cycle after cram_re)
//   stall                            downstream hold
//   data_valid, ram_data_out, ram_data_last  output beat stream
//   busy, done                       transfer status

// Small synchronous FIFO. The head is read straight from the storage register,
// so the consumer sees data in the same cycle the entry becomes the head.
module sync_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_vld) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_vld, pop_vld})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head output reads zero while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
endmodule

module cram_unload_streamer #(
  parameter int DWIDTH     = 40,
  parameter int AWIDTH     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] cram_addr_start,
  input  logic [AWIDTH:0]   num_words,
  output logic [AWIDTH-1:0] cram_addr,
  output logic              cram_re,
  input  logic [DWIDTH-1:0] cram_data_in,
  input  logic              stall,
  output logic              data_valid,
  output logic [DWIDTH-1:0] ram_data_out,
  output logic              ram_data_last,
  output logic              busy,
  output logic              done
);
  localparam int CW = AWIDTH + 1;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]     N_MAX    = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [CW-1:0]     C_ONE    = CW'(1);
  localparam logic [AWIDTH-1:0] A_ONE    = AWIDTH'(1);
  localparam logic [OW:0]       DEPTH_V  = (OW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]     n_q, n_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic [CW-1:0]     emitted_q, emitted_d;
  logic              inflight_q, inflight_d;

  logic [DWIDTH-1:0] fifo_head_dat;
  logic [OW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic [OW:0]       credit_used;

  sync_fifo #(.W(DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (inflight_q),
    .push_dat (cram_data_in),
    .pop_vld  (data_valid),
    .head_dat (fifo_head_dat),
    .count    (fifo_cnt),
    .empty    (fifo_empty)
  );

  assign data_valid   = !fifo_empty && !stall;
  assign ram_data_out = fifo_head_dat;

  // Words already buffered plus the one possibly arriving next edge; a read is
  // only issued when that total leaves room, so the FIFO can never overflow.
  assign credit_used = {1'b0, fifo_cnt} + (OW + 1)'(inflight_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    n_d       = n_q;
    issued_d  = issued_q;
    emitted_d = emitted_q + CW'(data_valid);
    cram_re   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = cram_addr_start;
          n_d       = (num_words > N_MAX) ? N_MAX : num_words;
          issued_d  = '0;
          emitted_d = '0;
          state_d   = (num_words == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if ((issued_q < n_q) && (credit_used < DEPTH_V)) begin
          cram_re  = 1'b1;
          addr_d   = addr_q + A_ONE;
          issued_d = issued_q + C_ONE;
          if (issued_d == n_q) state_d = S_DRAIN;
        end
      end
      // Leave on the cycle the final beat is popped so done lands right after it.
      S_DRAIN: begin
        if (emitted_d == n_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    inflight_d = cram_re;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      n_q        <= '0;
      issued_q   <= '0;
      emitted_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      issued_q   <= issued_d;
      emitted_q  <= emitted_d;
      inflight_q <= inflight_d;
    end
  end

  assign cram_addr     = addr_q;
  assign ram_data_last = data_valid && (emitted_q == (n_q - C_ONE));
  assign busy          = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_cram_unload_streamer.sv
// Directed vector bench for cram_unload_streamer with a behavioural one-cycle-latency CRAM.
module tb_cram_unload_streamer;
  localparam int DW = 40;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] cram_addr_start;
  logic [AW:0]   num_words;
  logic [AW-1:0] cram_addr;
  logic          cram_re;
  logic [DW-1:0] cram_data_in;
  logic          stall;
  logic          data_valid;
  logic [DW-1:0] ram_data_out;
  logic          ram_data_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  cram_unload_streamer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cram_addr_start (cram_addr_start),
    .num_words       (num_words),
    .cram_addr       (cram_addr),
    .cram_re         (cram_re),
    .cram_data_in    (cram_data_in),
    .stall           (stall),
    .data_valid      (data_valid),
    .ram_data_out    (ram_data_out),
    .ram_data_last   (ram_data_last),
    .busy            (busy),
    .done            (done)
  );

  // CRAM model: CRAM[i] = i, registered read.
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (cram_re) cram_data_in <= mem[cram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cram_re"}, 64'(cram_re), 64'd0);
    chk({tag, "_cram_addr"}, 64'(cram_addr), 64'd0);
    chk({tag, "_data_valid"}, 64'(data_valid), 64'd0);
    chk({tag, "_ram_data_out"}, 64'(ram_data_out), 64'd0);
    chk({tag, "_ram_data_last"}, 64'(ram_data_last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    logic [AW-1:0] a;        // start address
    logic [AW:0]   n;        // num_words driven
    int            s_lo;     // stall window (inclusive), s_lo > s_hi means none
    int            s_hi;
    bit            bst;      // pulse start (N=3, addr 300) at cycles 2, 7 and the done cycle
    int            e_beats;  // expected beats and reads
    int            e_first;  // expected cycle of first beat (0 = none)
    int            e_last;   // expected cycle of last beat (0 = none)
    int            e_done;   // expected done cycle
    int            e_max;    // expected peak of issued-minus-emitted
  } vec_t;

  vec_t vt [9];

  task automatic run_vec(input int k);
    vec_t v;
    int iss, emi, first, lastc, nlast, ndone, maxo;
    logic [AW-1:0] ea;
    v = vt[k];
    iss = 0; emi = 0; first = 0; lastc = 0; nlast = 0; ndone = 0; maxo = 0;
    @(posedge clk); #1;
    start = 1'b1; cram_addr_start = v.a; num_words = v.n; stall = 1'b0;
    for (int cyc = 1; cyc <= v.e_done + 2; cyc++) begin
      @(posedge clk); #1;
      start = v.bst && (cyc == 2 || cyc == 7 || cyc == v.e_done);
      cram_addr_start = start ? AW'(300) : v.a;
      num_words       = start ? (AW + 1)'(3) : v.n;
      stall = (cyc >= v.s_lo) && (cyc <= v.s_hi);
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_busy", k, cyc), 64'(busy), 64'(cyc < v.e_done));
      chk($sformatf("v%0d_c%0d_done", k, cyc), 64'(done), 64'(cyc == v.e_done));
      if (done) ndone++;
      if (stall) chk($sformatf("v%0d_c%0d_stall_hold", k, cyc), 64'(data_valid), 64'd0);
      if (cram_re) begin
        ea = v.a + iss[AW-1:0];
        chk($sformatf("v%0d_c%0d_addr", k, cyc), 64'(cram_addr), 64'(ea));
        iss++;
      end
      if (data_valid) begin
        if (first == 0) first = cyc;
        ea = v.a + emi[AW-1:0];
        chk($sformatf("v%0d_beat%0d_data", k, emi), 64'(ram_data_out), 64'(mem[ea]));
        chk($sformatf("v%0d_beat%0d_last", k, emi), 64'(ram_data_last), 64'(emi == v.e_beats - 1));
        if (ram_data_last) nlast++;
        emi++;
        lastc = cyc;
      end
      if (iss - emi > maxo) maxo = iss - emi;
    end
    chk($sformatf("v%0d_reads", k), 64'(iss), 64'(v.e_beats));
    chk($sformatf("v%0d_beats", k), 64'(emi), 64'(v.e_beats));
    chk($sformatf("v%0d_first_cycle", k), 64'(first), 64'(v.e_first));
    chk($sformatf("v%0d_last_cycle", k), 64'(lastc), 64'(v.e_last));
    chk($sformatf("v%0d_last_count", k), 64'(nlast), 64'(v.e_beats > 0));
    chk($sformatf("v%0d_done_count", k), 64'(ndone), 64'd1);
    chk($sformatf("v%0d_peak_outstanding", k), 64'(maxo), 64'(v.e_max));
  endtask

  initial begin
    int emi;
    for (int i = 0; i < 512; i++) mem[i] = DW'(i);

    //         a    n    s_lo s_hi bst beats first last done max
    vt[0] = '{9'd0,   10'd80,  0, -1, 1'b0,  80, 3,  82,  83, 2};  // basic
    vt[1] = '{9'd0,   10'd40, 10, 24, 1'b0,  40, 3,  57,  58, 4};  // mid-stream stall
    vt[2] = '{9'd500, 10'd20,  0, -1, 1'b0,  20, 3,  22,  23, 2};  // address wrap
    vt[3] = '{9'd5,   10'd0,   0, -1, 1'b0,   0, 0,   0,   1, 0};  // zero length
    vt[4] = '{9'd100, 10'd600, 0, -1, 1'b0, 512, 3, 514, 515, 2};  // clamp to 512
    vt[5] = '{9'd0,   10'd10,  0, -1, 1'b1,  10, 3,  12,  13, 2};  // start while busy
    vt[6] = '{9'd511, 10'd1,   0, -1, 1'b0,   1, 3,   3,   4, 1};  // single word
    vt[7] = '{9'd10,  10'd6,   8,  9, 1'b0,   6, 3,  10,  11, 2};  // stall holds last beat
    vt[8] = '{9'd200, 10'd5,   0, -1, 1'b0,   5, 3,   7,   8, 2};  // fresh run after reset

    reset = 1'b1; start = 1'b0; stall = 1'b0;
    cram_addr_start = '0; num_words = '0;
    #2;
    chk_outputs_zero("por");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(k);

    // Reset in the middle of a transfer, once 17 beats have gone out.
    emi = 0;
    @(posedge clk); #1;
    start = 1'b1; cram_addr_start = '0; num_words = 10'd40; stall = 1'b0;
    for (int c = 1; c <= 60 && emi < 17; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (data_valid) emi++;
    end
    chk("mid_rst_reached_word17", 64'(emi), 64'd17);
    chk("mid_rst_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_outputs_zero("mid_rst_async");
    @(posedge clk); @(posedge clk); #1;
    chk_outputs_zero("mid_rst_held");
    @(negedge clk);
    reset = 1'b0;
    run_vec(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cram_unload_streamer.md
# cram_unload_streamer

Read-side sequencer that sits directly upstream of the CRAM-to-DRAM swizzle stage. On a start pulse it reads a programmed number of 40-bit words from one compute-RAM port, starting at a programmable address. It absorbs the RAM's one-cycle read latency in a small credit-controlled FIFO and presents the words as a valid/last beat stream (`data_valid`, `ram_data_out`, `ram_data_last`) with a downstream stall input.

## Interface
- `DWIDTH`, 40, CRAM word width; equals the swizzle's RAM port width.
- `AWIDTH`, 9, CRAM address width; 2^AWIDTH = 512 words per port.
- `FIFO_DEPTH`, 4, output FIFO entries (power of two, ≥ 2).
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle request to begin a transfer.
- `cram_addr_start` in AWIDTH: first CRAM address; sampled with `start`.
- `num_words` in AWIDTH+1: words to stream; sampled with `start`.
- `cram_addr` out AWIDTH: CRAM read address.
- `cram_re` out 1: CRAM read enable.
- `cram_data_in` in DWIDTH: CRAM read data, valid exactly one cycle after `cram_re`.
- `stall` in 1: downstream hold; no beat is emitted while high.
- `data_valid` out 1: an output beat is present this cycle.
- `ram_data_out` out DWIDTH: beat data.
- `ram_data_last` out 1: marks the final beat of the transfer; only meaningful with `data_valid`.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse when a transfer completes.

## Operation
- **States:**
  - IDLE: `start` → READ.
  - READ: all reads issued → DRAIN.
  - DRAIN: FIFO empty and no read in flight → DONE.
  - DONE: → IDLE after one cycle.
- **Start sampling:**
  - `start` is accepted only in IDLE; it is ignored in every other state.
  - On accept, `cram_addr_start`, `num_words`, the issue counter and the emit counter are latched.
- **Word count rules:**
  - `num_words` = 0 → IDLE goes straight to DONE; no reads and no beats.
  - `num_words` > 512 → clamped to 512.
- **Issue rule (READ):**
  - `cram_re` = 1 when issued < N and occupancy + inflight < FIFO_DEPTH.
  - `inflight` is a 1-bit flag meaning "read issued last cycle".
  - `cram_addr` increments after each issued read and wraps modulo 2^AWIDTH.
- **FIFO:**
  - The word is written on the cycle `cram_data_in` is valid.
  - Pop condition: `data_valid` = !empty & !stall. The pop happens on the same cycle.
  - `ram_data_out` = FIFO head (combinational from the storage register).
  - The credit rule guarantees no overflow.
  - A simultaneous push and pop leaves occupancy unchanged.
- **Last beat:** `ram_data_last` = `data_valid` & (emitted == N−1).
- **Busy/done:**
  - `busy` = state ≠ IDLE, excluding DONE.
  - `done` = 1 only in DONE.
- **Reset values:**
  - State IDLE, counters 0, FIFO empty, inflight 0.
  - All outputs 0, including `cram_addr`.
- **Reset mid-transfer:** aborts immediately, discards buffered and in-flight data, and emits no partial `ram_data_last`.
- **Stall:**
  - A stall of any length loses and duplicates nothing.
  - At most FIFO_DEPTH words are buffered; issuing stops once occupancy + inflight reaches FIFO_DEPTH.

## Timing
- `start` is sampled at edge E0.
- `cram_re` is first high in cycle 1 with `cram_addr` = start.
- The data is captured at E2; first `data_valid` is in cycle 3 when not stalled. Start-to-first-beat latency is 3 cycles.
- With no stall, throughput is one beat per cycle: steady-state occupancy is 1 and inflight is 1.
- N beats occupy cycles 3..N+2. The last beat is in cycle N+2.
- `done` = 1 in cycle N+3, `busy` = 0 in cycle N+3, and the block returns to IDLE at cycle N+4.
- `start` is accepted again from cycle N+4.
- Stall release: when `stall` falls, `data_valid` may rise in the same cycle if the FIFO is non-empty.

## Test plan
- **Basic stream:** start=0, N=80, stall=0, CRAM[i]=i → `cram_re` high in cycles 1..80 with addr 0..79. `data_valid` high in cycles 3..82 with data 0..79. `ram_data_last` only in cycle 82. `done` pulse in cycle 83.
- **Mid-stream stall:** N=40, `stall` high in cycles 10..24 → no beats in cycles 10..24. `cram_re` stops once 4 words are buffered and resumes after release. Output is exactly 0..39 in order; last at word 39.
- **Address wrap:** start=500, N=20 → read addresses 500..511 then 0..7. Beats carry CRAM[500..511], CRAM[0..7].
- **Zero length:** N=0 → `done` high in cycle 1. `busy`, `cram_re` and `data_valid` never assert.
- **Clamp:** N=600 → exactly 512 beats, last on the 512th, addresses wrap to start−1.
- **Busy-start and reset:**
  - Start pulses while busy → ignored; the count is unchanged.
  - `reset` asserted mid-transfer at word 17 → all outputs 0 asynchronously and the FIFO is empty.
  - After deassert, a new start with N=5 yields exactly 5 fresh beats.
